dct2d_seq_ctrl: RTL and testbench

DCT2D_SEQ_CTRL -- requirements
Module: dct2d_seq_ctrl

---
 rtl/dct2d_seq_ctrl_if.sv | 31 +++
 rtl/dct2d_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_dct2d_seq_ctrl.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dct2d_seq_ctrl_if.sv
// Handshake and engine bundle for the 2D DCT sequencing controller.
// The controller drives through master; the engine/stream side uses slave.
interface dct2d_seq_ctrl_if #(
    parameter int N = 4,
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           eng_start;
    logic           eng_done;
    logic [N*W-1:0] eng_x;
    logic [N*W-1:0] eng_y;
    logic           busy;

    modport master (
        input  in_valid, in_data, out_ready, eng_done, eng_y,
        output in_ready, out_valid, out_data, out_last,
        output eng_start, eng_x, busy
    );

    modport slave (
        output in_valid, in_data, out_ready, eng_done, eng_y,
        input  in_ready, out_valid, out_data, out_last,
        input  eng_start, eng_x, busy
    );
endinterface

// File: rtl/dct2d_seq_ctrl.sv
// Row/column sequencer around an external 1D DCT engine for an NxN block.
// Buffer A holds input then final coefficients; buffer R holds row results.
module dct2d_seq_ctrl #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset,
    dct2d_seq_ctrl_if.master bus
);
    localparam int NW = $clog2(N);
    localparam int KW = $clog2(N * N);
    localparam logic [NW-1:0] LAST_N = NW'(N - 1);
    localparam logic [KW-1:0] LAST_K = KW'(N * N - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_ROW_START,
        S_ROW_WAIT,
        S_COL_START,
        S_COL_WAIT,
        S_UNLOAD
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [NW-1:0]  r_r;
    logic [NW-1:0]  r_c;
    logic [KW-1:0]  r_k;
    logic           r_first;
    logic [W-1:0]   r_a  [N][N];
    logic [W-1:0]   r_rb [N][N];

    logic           w_acc;
    logic           w_row_cap;
    logic           w_col_cap;
    logic           w_ohs;
    logic           w_klast;
    logic [NW-1:0]  w_krow;
    logic [NW-1:0]  w_kcol;

    assign w_krow    = r_k[KW-1:NW];
    assign w_kcol    = r_k[NW-1:0];
    assign w_klast   = (r_k == LAST_K);
    assign w_acc     = (r_state == S_LOAD) && bus.in_valid;
    assign w_ohs     = (r_state == S_UNLOAD) && bus.out_ready;
    // the first WAIT cycle may still show the previous result's done
    assign w_row_cap = (r_state == S_ROW_WAIT) && !r_first && bus.eng_done;
    assign w_col_cap = (r_state == S_COL_WAIT) && !r_first && bus.eng_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:
                if (w_acc && w_klast) w_next = S_ROW_START;
            S_ROW_START:
                w_next = S_ROW_WAIT;
            S_ROW_WAIT:
                if (w_row_cap)
                    w_next = (r_r == LAST_N) ? S_COL_START : S_ROW_START;
            S_COL_START:
                w_next = S_COL_WAIT;
            S_COL_WAIT:
                if (w_col_cap)
                    w_next = (r_c == LAST_N) ? S_UNLOAD : S_COL_START;
            S_UNLOAD:
                if (w_ohs && w_klast) w_next = S_LOAD;
            default:
                w_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_LOAD;
            r_r     <= '0;
            r_c     <= '0;
            r_k     <= '0;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (r_state == S_ROW_START) || (r_state == S_COL_START);
            if (w_acc || w_ohs)
                r_k <= w_klast ? '0 : r_k + 1'b1;
            if (w_row_cap)
                r_r <= (r_r == LAST_N) ? '0 : r_r + 1'b1;
            if (w_col_cap)
                r_c <= (r_c == LAST_N) ? '0 : r_c + 1'b1;
        end
    end

    // data storage carries no reset; control state gates every write
    always_ff @(posedge clk) begin
        if (w_acc)
            r_a[w_krow][w_kcol] <= bus.in_data;
        for (int i = 0; i < N; i++) begin
            if (w_row_cap)
                r_rb[r_r][i] <= bus.eng_y[i*W +: W];
            if (w_col_cap)
                r_a[i][r_c] <= bus.eng_y[i*W +: W];
        end
    end

    always_comb begin
        bus.eng_x = '0;
        for (int i = 0; i < N; i++) begin
            if (r_state == S_COL_START)
                bus.eng_x[i*W +: W] = r_rb[i][r_c];
            else
                bus.eng_x[i*W +: W] = r_a[r_r][i];
        end
    end

    assign bus.in_ready  = (r_state == S_LOAD);
    assign bus.busy      = (r_state != S_LOAD);
    assign bus.out_valid = (r_state == S_UNLOAD);
    assign bus.out_last  = (r_state == S_UNLOAD) && w_klast;
    assign bus.out_data  = r_a[w_krow][w_kcol];
    assign bus.eng_start = (r_state == S_ROW_START) ||
                           (r_state == S_COL_START);
endmodule

// File: tb/tb_dct2d_seq_ctrl.sv
// Scoreboard bench for dct2d_seq_ctrl with a behavioural 1D engine model.
// Engine is identity or lane-reverse, with fixed or always-high done.
module tb_dct2d_seq_ctrl;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int NN = N * N;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dct2d_seq_ctrl_if #(.N(N), .W(W)) bus ();

    dct2d_seq_ctrl #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // engine model
    int             eng_d = 3;
    bit             rev = 1'b0;
    bit             done_always = 1'b0;
    logic [N*W-1:0] lat = '0;
    int             cnt;

    function automatic logic [N*W-1:0] revf(input logic [N*W-1:0] x);
        logic [N*W-1:0] y;
        y = '0;
        for (int i = 0; i < N; i++) y[i*W +: W] = x[(N-1-i)*W +: W];
        return y;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) cnt <= 0;
        else if (bus.eng_start) begin
            lat <= bus.eng_x;
            cnt <= 1;
        end else if (cnt == eng_d) cnt <= 0;
        else if (cnt != 0) cnt <= cnt + 1;
    end

    assign bus.eng_y    = rev ? revf(lat) : lat;
    assign bus.eng_done = done_always | (cnt == eng_d);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W-1:0] q[$];
    int  last_acc = 0;
    int  lat_exp = 32;
    bit  gap_en = 1'b0;
    bit  stall_en = 1'b0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // output monitor
    bit           p_stall = 0;
    logic [W-1:0] p_data;
    logic         p_last;
    bit           p_lasths = 0;
    bit           p_start = 0;
    bit           seen = 0;
    int           out_idx = 0;
    int           n_starts = 0;
    int           last_start = 0;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_start", bus.eng_start, 0);
            chk("rst_oval", bus.out_valid, 0);
            chk("rst_olast", bus.out_last, 0);
            chk("rst_irdy", bus.in_ready, 1);
            chk("rst_busy", bus.busy, 0);
            p_stall = 0; p_lasths = 0; p_start = 0;
            seen = 0; out_idx = 0; n_starts = 0;
        end else begin
            if (p_lasths) chk("irdy_rise", bus.in_ready, 1);
            if (bus.out_valid) chk("no_overlap", bus.in_ready, 0);
            if (p_stall) begin
                chk("stall_v", bus.out_valid, 1);
                chk("stall_d", bus.out_data, p_data);
                chk("stall_l", bus.out_last, p_last);
            end
            if (bus.eng_start) begin
                chk("start_pulse", p_start, 0);
                if (!done_always) chk("restart", cnt, 0);
                if (n_starts > 0) chk("wait_len", (cyc - last_start) >= 3, 1);
                last_start = cyc;
                n_starts++;
            end
            p_start = bus.eng_start;
            if (bus.out_valid && !seen) begin
                seen = 1;
                chk("latency", cyc - last_acc, lat_exp);
            end
            p_lasths = 0;
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) chk("q_empty", 1, 0);
                else chk("data", bus.out_data, q.pop_front());
                chk("last", bus.out_last, out_idx == NN - 1);
                if (bus.out_last) begin
                    chk("starts", n_starts, 2 * N);
                    n_starts = 0;
                    seen = 0;
                    p_lasths = 1;
                end
                out_idx = (out_idx + 1) % NN;
            end
            p_stall = bus.out_valid && !bus.out_ready;
            p_data  = bus.out_data;
            p_last  = bus.out_last;
        end
    end

    task automatic send_block(input logic [W-1:0] blk[NN]);
        int t;
        for (int u = 0; u < N; u++)
            for (int v = 0; v < N; v++)
                q.push_back(rev ? blk[(N-1-u)*N + (N-1-v)] : blk[u*N + v]);
        for (int k = 0; k < NN; k++) begin
            if (gap_en) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = blk[k];
            t = 0;
            @(negedge clk);
            while (!bus.in_ready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (t >= 3000) chk("in_tmo", 0, 1);
            @(posedge clk);
            #1;
            last_acc     = cyc;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        chk("drain", q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [W-1:0] blk[NN];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        chk("idle_rdy", bus.in_ready, 1);
        chk("idle_busy", bus.busy, 0);

        for (int k = 0; k < NN; k++) blk[k] = W'(k);
        send_block(blk);
        drain();

        rev = 1'b1;
        send_block(blk);
        drain();
        rev = 1'b0;

        gap_en = 1'b1;
        stall_en = 1'b1;
        for (int b = 0; b < 20; b++) begin
            if (b == 10) begin
                drain();
                rev = 1'b1;
            end
            for (int k = 0; k < NN; k++) blk[k] = W'($urandom);
            send_block(blk);
        end
        drain();
        rev = 1'b0;
        gap_en = 1'b0;
        stall_en = 1'b0;

        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < NN; k++) blk[k] = W'(100 * b + k);
            send_block(blk);
        end
        drain();

        done_always = 1'b1;
        lat_exp = 24;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NN; k++) blk[k] = W'($urandom);
            send_block(blk);
        end
        drain();
        done_always = 1'b0;
        lat_exp = 32;

        for (int k = 0; k < NN; k++) blk[k] = W'(k);
        send_block(blk);
        @(posedge clk);
        #1;
        chk("mid_busy", bus.busy, 1);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        q.delete();
        reset = 1'b1;
        for (int k = 0; k < NN; k++) blk[k] = W'(64);
        send_block(blk);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
        $fatal(1, "watchdog");
    end
endmodule
